// File: rtl/store_merge.sv
// rtl/store_merge.sv - sub-word store engine: read-modify-write merge for SB/SH, direct write for SW
// Optional alignment check enabled by defining STORE_ALIGN_CHECK_EN.
module store_merge (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SB = 6'b101000;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_d;
  logic        is_sw, is_sh, is_sb, mis, accept;
  logic        is_sb_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [31:0] merged;
  logic        busy_d, rd_d, wr_d, done_d;

  // Decode the incoming opcode; only meaningful while IDLE
  always_comb begin
    is_sw  = (op == OP_SW);
    is_sh  = (op == OP_SH);
    is_sb  = (op == OP_SB);
    accept = (state == IDLE) && start;
  end

`ifdef STORE_ALIGN_CHECK_EN
  // Misaligned SW/SH are rejected without touching memory
  always_comb begin
    mis = (is_sw && (addr[1:0] != 2'b00)) || (is_sh && addr[0]);
  end
`else
  assign mis = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (mis)                state_d = DONE;
          else if (is_sw)         state_d = WRITE;
          else if (is_sb || is_sh) state_d = READ;
          else                    state_d = DONE;
        end
      end
      READ:    if (mem_ready) state_d = WRITE;
      WRITE:   if (mem_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so every output comes straight from a flop
  always_comb begin
    busy_d = (state_d != IDLE);
    rd_d   = (state_d == READ);
    wr_d   = (state_d == WRITE);
    done_d = (state_d == DONE);
  end

  // Merge the latched store data into the word being read back
  always_comb begin
    merged = mem_rdata;
    if (is_sb_q) begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  // Control output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy   <= busy_d;
      mem_rd <= rd_d;
      mem_wr <= wr_d;
      done   <= done_d;
    end
  end

  // Request latches and address/data outputs; held steady until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_sb_q   <= 1'b0;
      lane_q    <= 2'b00;
      wdata_q   <= 16'h0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else if (accept) begin
      is_sb_q   <= is_sb;
      lane_q    <= addr[1:0];
      wdata_q   <= wdata[15:0];
      mem_addr  <= {addr[31:2], 2'b00};
      mem_wdata <= wdata;
    end else if ((state == READ) && mem_ready) begin
      mem_wdata <= merged;
    end
  end

`ifdef STORE_ALIGN_CHECK_EN
  // Error pulse lines up with done because a rejected request goes straight to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= accept && mis;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_store_merge.sv
// tb/tb_store_merge.sv - directed self-checking bench for store_merge
module tb_store_merge;

  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SB = 6'b101000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  op = 6'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata = 32'h11223344;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        busy, done, err;

  int total = 0;
  int bad = 0;

  int cyc = 0;
  int rd_n = 0, wr_n = 0, done_n = 0, err_n = 0, both_n = 0;
  int done_cyc = 0, last_wr_cyc = 0, start_cyc = 0, stall = 0;
  logic [31:0] wr_data = 32'h0, wr_addr = 32'h0;
  logic        err_at_done = 1'b0;

  store_merge dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .addr(addr), .wdata(wdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Memory stalls the first 'stall' write cycles of each request
  assign mem_ready = !mem_wr || (wr_n > stall);

  // Observe outputs mid-cycle
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_rd) rd_n = rd_n + 1;
    if (mem_wr) begin
      wr_n = wr_n + 1;
      wr_data = mem_wdata;
      wr_addr = mem_addr;
      last_wr_cyc = cyc;
    end
    if (mem_rd && mem_wr) both_n = both_n + 1;
    if (err) err_n = err_n + 1;
    if (done) begin
      done_n = done_n + 1;
      done_cyc = cyc;
      err_at_done = err;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    rd_n = 0; wr_n = 0; done_n = 0; err_n = 0; both_n = 0;
    done_cyc = 0; last_wr_cyc = 0;
  endtask

  // Issue one request, optionally poke start once during WRITE, wait for done
  task automatic do_store(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                          input int st, input bit poke);
    bit poked;
    poked = 1'b0;
    @(negedge clk); #1;
    clear_counts();
    stall = st;
    op = o; addr = a; wdata = d; start = 1'b1;
    start_cyc = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && done_n == 0; i++) begin
      if (poke && mem_wr && !poked) begin
        start = 1'b1; op = OP_SB; addr = 32'h200; wdata = 32'h55;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk); #1;
    end
    start = 1'b0;
    check("done_seen", 32'(done_n != 0), 32'd1);
    @(negedge clk); #1;
    check("done_once", done_n, 1);
    check("idle_after", {30'h0, busy, done}, 32'h0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rd", mem_rd, 0);
    check("rst_wr", mem_wr, 0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // SB lane 3
    do_store(OP_SB, 32'h103, 32'hAB, 0, 1'b0);
    check("sb3_data", wr_data, 32'hAB223344);
    check("sb3_addr", wr_addr, 32'h100);
    check("sb3_lat", done_cyc - start_cyc, 3);
    check("sb3_rd", rd_n, 1);
    check("sb3_wr", wr_n, 1);
    check("sb3_both", both_n, 0);

    // SB other lanes
    do_store(OP_SB, 32'h100, 32'hAB, 0, 1'b0);
    check("sb0_data", wr_data, 32'h112233AB);
    do_store(OP_SB, 32'h101, 32'hAB, 0, 1'b0);
    check("sb1_data", wr_data, 32'h1122AB44);
    do_store(OP_SB, 32'h102, 32'hAB, 0, 1'b0);
    check("sb2_data", wr_data, 32'h11AB3344);

    // SH both halves
    do_store(OP_SH, 32'h102, 32'h0000BEEF, 0, 1'b0);
    check("shh_data", wr_data, 32'hBEEF3344);
    check("shh_lat", done_cyc - start_cyc, 3);
    do_store(OP_SH, 32'h100, 32'h0000BEEF, 0, 1'b0);
    check("shl_data", wr_data, 32'h1122BEEF);

    // SW no stall
    do_store(OP_SW, 32'h40, 32'hCAFEF00D, 0, 1'b0);
    check("sw_data", wr_data, 32'hCAFEF00D);
    check("sw_lat", done_cyc - start_cyc, 2);
    check("sw_rd", rd_n, 0);

    // SW with three stalled write cycles and a start poked during WRITE
    do_store(OP_SW, 32'h20, 32'hDEADBEEF, 3, 1'b1);
    check("sws_wr", wr_n, 4);
    check("sws_rd", rd_n, 0);
    check("sws_data", wr_data, 32'hDEADBEEF);
    check("sws_addr", wr_addr, 32'h20);
    check("sws_gap", done_cyc - last_wr_cyc, 1);
    repeat (4) @(negedge clk);
    #1;
    check("poke_wr", wr_n, 4);
    check("poke_rd", rd_n, 0);
    check("poke_done", done_n, 1);
    check("poke_busy", busy, 0);

    // Undefined op
    do_store(6'b000000, 32'h300, 32'h12345678, 0, 1'b0);
    check("undef_err", err_at_done, 0);
    check("undef_rd", rd_n, 0);
    check("undef_wr", wr_n, 0);
    check("undef_lat", done_cyc - start_cyc, 1);

    // Alignment
    do_store(OP_SH, 32'h101, 32'h0000BEEF, 0, 1'b0);
`ifdef STORE_ALIGN_CHECK_EN
    check("al_err", err_at_done, 1);
    check("al_errn", err_n, 1);
    check("al_rd", rd_n, 0);
    check("al_wr", wr_n, 0);
`else
    check("al_err", err_n, 0);
    check("al_data", wr_data, 32'h1122BEEF);
    check("al_addr", wr_addr, 32'h100);
    check("al_rd", rd_n, 1);
`endif

    // Reset during READ
    @(negedge clk); #1;
    clear_counts();
    stall = 0;
    op = OP_SB; addr = 32'h180; wdata = 32'h77; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    check("rr_inread", mem_rd, 1);
    rst_n = 1'b0;
    #1;
    check("rr_rd", mem_rd, 0);
    check("rr_busy", busy, 0);
    check("rr_addr", mem_addr, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("rr_nodone", done_n, 0);
    check("rr_nowr", wr_n, 0);

    // Accepts immediately after reset release
    do_store(OP_SW, 32'h44, 32'h0BADF00D, 0, 1'b0);
    check("post_rst", wr_data, 32'h0BADF00D);
    check("post_both", both_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
